fetch_stage_ctrl: RTL and testbench

Parametrised instruction-fetch stage: owns the PC register, presents the fetch address to instruction memory, and registers the IF/ID pipeline outputs (instruction, PC, PC+step, valid).

---
 rtl/fetch_stage_ctrl_pkg.sv | 14 +
 rtl/fetch_stage_ctrl_pc_reg_ctrl.sv | 43 ++++
 rtl/fetch_stage_ctrl.sv | 110 +++++++++++
 tb/tb_fetch_stage_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_ctrl_pkg.sv
// Shared definitions for the instruction-fetch stage: default widths,
// the bubble instruction and the two-state sequencing FSM encoding.
package fetch_stage_ctrl_pkg;

    localparam int          XLEN_DEFAULT      = 32;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    // Fetch sequencing states; kept as plain constants so older tools that
    // predate enum support can still consume the package.
    typedef logic [0:0] fetch_state_t;
    localparam fetch_state_t S_RUN   = 1'b0;
    localparam fetch_state_t S_REDIR = 1'b1;

endpackage

// File: rtl/fetch_stage_ctrl_pc_reg_ctrl.sv
// PC register with its next-PC selection: reset vector, redirect target,
// sequential increment, or hold.
module pc_reg_ctrl #(
    parameter int               XLEN     = 32,
    parameter int               PC_STEP  = 1,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            advance,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_next
);

    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] pc_q;

    // Sequential successor; the add is XLEN wide so it wraps silently.
    assign pc_next = pc_q + XLEN'(PC_STEP);
    assign pc      = pc_q;

    // Next-PC mux: a redirect beats any stall/advance decision.
    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = redirect_pc;
        end else if (advance) begin
            pc_d = pc_next;
        end
    end

    // PC register with synchronous reset to the configured vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/fetch_stage_ctrl.sv
// Instruction-fetch stage: drives the fetch address from the PC, registers
// the IF/ID slot, and handles stall, flush, redirect and memory back-pressure.
module fetch_stage_ctrl
    import fetch_stage_ctrl_pkg::*;
#(
    parameter int               XLEN      = XLEN_DEFAULT,
    parameter int               PC_STEP   = 1,
    parameter logic [XLEN-1:0]  RESET_PC  = '0,
    parameter logic [31:0]      NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_d,
    input  logic            flush_d,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_ready,
    output logic [31:0]     instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pc_plus_d,
    output logic            valid_d
);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
    logic            advance;

    logic [31:0]     ifid_instr_d,   ifid_instr_q;
    logic [XLEN-1:0] ifid_pc_d,      ifid_pc_q;
    logic [XLEN-1:0] ifid_pc_plus_d, ifid_pc_plus_q;
    logic            ifid_valid_d,   ifid_valid_q;
    fetch_state_t    state_d,        state_q;

    // The PC moves on whenever the fetched word is consumed or squashed by a
    // flush; a stall freezes it and an unready memory leaves it pending.
    assign advance = !redirect && !stall_d && imem_ready;

    pc_reg_ctrl #(
        .XLEN     (XLEN),
        .PC_STEP  (PC_STEP),
        .RESET_PC (RESET_PC)
    ) u_pc_reg_ctrl (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .advance     (advance),
        .pc          (pc),
        .pc_next     (pc_next)
    );

    assign imem_addr = pc;
    assign instr_d   = ifid_instr_q;
    assign pc_d      = ifid_pc_q;
    assign pc_plus_d = ifid_pc_plus_q;
    assign valid_d   = ifid_valid_q;

    // IF/ID slot and FSM update, in priority order redirect > stall > bubble > load.
    always_comb begin
        ifid_instr_d   = ifid_instr_q;
        ifid_pc_d      = ifid_pc_q;
        ifid_pc_plus_d = ifid_pc_plus_q;
        ifid_valid_d   = ifid_valid_q;
        state_d        = S_RUN;
        if (redirect) begin
            // The decode-side instruction is wrong-path even if stalled.
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
            state_d      = S_REDIR;
        end else if (stall_d) begin
            // Hold everything; a pending flush waits for the stall to clear.
        end else if (flush_d || !imem_ready) begin
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
        end else begin
            ifid_instr_d   = imem_rdata;
            ifid_pc_d      = pc;
            ifid_pc_plus_d = pc_next;
            ifid_valid_d   = 1'b1;
        end
    end

    // IF/ID pipeline register and sequencing state.
    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_instr_q   <= NOP_INSTR;
            ifid_pc_q      <= '0;
            ifid_pc_plus_q <= '0;
            ifid_valid_q   <= 1'b0;
            state_q        <= S_RUN;
        end else begin
            ifid_instr_q   <= ifid_instr_d;
            ifid_pc_q      <= ifid_pc_d;
            ifid_pc_plus_q <= ifid_pc_plus_d;
            ifid_valid_q   <= ifid_valid_d;
            state_q        <= state_d;
        end
    end

    // The cycle after a redirect always starts with a bubble in IF/ID.
    always @(posedge clk) begin
        if (!rst && state_q == S_REDIR) begin
            assert (!ifid_valid_q)
                else $error("IF/ID valid during redirect-recovery cycle");
        end
    end

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Randomised bench for fetch_stage_ctrl: two instances (32-bit byte-addressed
// and 16-bit word-addressed near the wrap point) share control stimulus and
// are compared every cycle against a behavioural model of the fetch rules.
module tb_fetch_stage_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] instr;
        logic [63:0] pcd;
        logic [63:0] pcplus;
        logic [63:0] valid;
        logic [63:0] redir;
    } model_t;

    logic        clk = 1'b0;
    logic        rst, stall_d, flush_d, redirect, imem_ready;
    logic [31:0] redirect_pc32, imem_addr32, imem_rdata32, instr_d32, pc_d32, pc_plus_d32;
    logic        valid_d32;
    logic [15:0] redirect_pc16, imem_addr16, pc_d16, pc_plus_d16;
    logic [31:0] imem_rdata16, instr_d16;
    logic        valid_d16;

    int     n_cmp = 0;
    int     n_bad = 0;
    int     cyc   = 0;
    bit     model_ok = 1'b0;
    model_t m32, m16;

    always #5 clk = ~clk;

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    assign imem_rdata32 = mem_word({32'b0, imem_addr32});
    assign imem_rdata16 = mem_word({48'b0, imem_addr16});

    fetch_stage_ctrl #(
        .XLEN(32), .PC_STEP(4), .RESET_PC(32'h100), .NOP_INSTR(NOP)
    ) dut (
        .clk(clk), .rst(rst), .stall_d(stall_d), .flush_d(flush_d),
        .redirect(redirect), .redirect_pc(redirect_pc32),
        .imem_addr(imem_addr32), .imem_rdata(imem_rdata32), .imem_ready(imem_ready),
        .instr_d(instr_d32), .pc_d(pc_d32), .pc_plus_d(pc_plus_d32), .valid_d(valid_d32)
    );

    fetch_stage_ctrl #(
        .XLEN(16), .PC_STEP(1), .RESET_PC(16'hFFFF), .NOP_INSTR(NOP)
    ) dut16 (
        .clk(clk), .rst(rst), .stall_d(stall_d), .flush_d(flush_d),
        .redirect(redirect), .redirect_pc(redirect_pc16),
        .imem_addr(imem_addr16), .imem_rdata(imem_rdata16), .imem_ready(imem_ready),
        .instr_d(instr_d16), .pc_d(pc_d16), .pc_plus_d(pc_plus_d16), .valid_d(valid_d16)
    );

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // One edge of the fetch stage as the rules describe it.
    function automatic model_t mstep(input model_t m, input bit r, input bit rd,
                                     input logic [63:0] rpc, input bit st, input bit fl,
                                     input bit rdy, input logic [63:0] step,
                                     input logic [63:0] mask, input logic [63:0] rvec);
        model_t      n = m;
        logic [63:0] seq = (m.pc + step) & mask;
        if (r) begin
            n.pc = rvec; n.valid = 0; n.instr = NOP; n.pcd = 0; n.pcplus = 0; n.redir = 0;
        end else if (rd) begin
            n.pc = rpc & mask; n.valid = 0; n.instr = NOP; n.redir = 1;
        end else begin
            n.redir = 0;
            if (st) begin
                n.redir = 0;
            end else if (fl) begin
                n.valid = 0; n.instr = NOP;
                if (rdy) n.pc = seq;
            end else if (!rdy) begin
                n.valid = 0; n.instr = NOP;
            end else begin
                n.instr = {32'b0, mem_word(m.pc)};
                n.pcd = m.pc; n.pcplus = seq; n.valid = 1; n.pc = seq;
            end
        end
        return n;
    endfunction

    task automatic cycle(input bit r, input bit rd, input logic [31:0] rp32,
                         input logic [15:0] rp16, input bit st, input bit fl, input bit rdy);
        model_t n32, n16;
        rst = r; redirect = rd; redirect_pc32 = rp32; redirect_pc16 = rp16;
        stall_d = st; flush_d = fl; imem_ready = rdy;
        #1;
        if (model_ok) begin
            expect_eq("imem_addr32", {32'b0, imem_addr32}, m32.pc);
            expect_eq("imem_addr16", {48'b0, imem_addr16}, m16.pc);
        end
        n32 = mstep(m32, r, rd, {32'b0, rp32}, st, fl, rdy, 64'd4, 64'hFFFF_FFFF, 64'h100);
        n16 = mstep(m16, r, rd, {48'b0, rp16}, st, fl, rdy, 64'd1, 64'hFFFF, 64'hFFFF);
        @(posedge clk);
        #1;
        cyc++;
        m32 = n32;
        m16 = n16;
        if (r) model_ok = 1'b1;
        if (model_ok) begin
            expect_eq("valid32",  {63'b0, valid_d32},   m32.valid);
            expect_eq("instr32",  {32'b0, instr_d32},   m32.instr);
            expect_eq("pc_d32",   {32'b0, pc_d32},      m32.pcd);
            expect_eq("pcplus32", {32'b0, pc_plus_d32}, m32.pcplus);
            expect_eq("state32",  {63'b0, dut.state_q}, m32.redir);
            expect_eq("valid16",  {63'b0, valid_d16},   m16.valid);
            expect_eq("instr16",  {32'b0, instr_d16},   m16.instr);
            expect_eq("pc_d16",   {48'b0, pc_d16},      m16.pcd);
            expect_eq("pcplus16", {48'b0, pc_plus_d16}, m16.pcplus);
        end
        $display("cyc %0d rst=%b rd=%b st=%b fl=%b rdy=%b | addr=%h v=%b pc_d=%h instr=%h | addr16=%h v16=%b pc_d16=%h",
                 cyc, r, rd, st, fl, rdy, imem_addr32, valid_d32, pc_d32, instr_d32,
                 imem_addr16, valid_d16, pc_d16);
    endtask

    initial begin
        // Reset for two cycles, then free-running fetch.
        cycle(1, 0, 0, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 0, 0, 1);
        expect_eq("rst_addr", {32'b0, imem_addr32}, 64'h100);
        expect_eq("rst_instr", {32'b0, instr_d32}, {32'b0, NOP});
        cycle(0, 0, 0, 0, 0, 0, 1);
        expect_eq("t1_pc0", {32'b0, pc_d32}, 64'h100);
        // 16-bit instance wraps from 0xFFFF to 0x0000.
        expect_eq("wrap_plus", {48'b0, pc_plus_d16}, 64'h0);
        expect_eq("wrap_addr", {48'b0, imem_addr16}, 64'h0);
        cycle(0, 0, 0, 0, 0, 0, 1);
        expect_eq("t1_pc1", {32'b0, pc_d32}, 64'h104);
        // Three-cycle stall holds pc_d at 0x104.
        repeat (3) begin
            cycle(0, 0, 0, 0, 1, 0, 1);
            expect_eq("t2_hold", {32'b0, pc_d32}, 64'h104);
        end
        cycle(0, 0, 0, 0, 0, 0, 1);
        expect_eq("t2_resume", {32'b0, pc_d32}, 64'h108);
        // Redirect during a stall.
        cycle(0, 1, 32'h200, 16'h0200, 1, 0, 1);
        expect_eq("t3_bubble", {63'b0, valid_d32}, 64'h0);
        expect_eq("t3_addr", {32'b0, imem_addr32}, 64'h200);
        cycle(0, 0, 0, 0, 0, 0, 1);
        expect_eq("t3_target", {32'b0, pc_d32}, 64'h200);
        // Memory not ready for two cycles at 0x10.
        cycle(0, 1, 32'h10, 16'h0010, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        expect_eq("t4_addr", {32'b0, imem_addr32}, 64'h10);
        cycle(0, 0, 0, 0, 0, 0, 1);
        expect_eq("t4_once", {32'b0, pc_d32}, 64'h10);
        // Reset while in the redirect-recovery cycle with a stall pending.
        cycle(0, 1, 32'h300, 16'h0300, 0, 0, 1);
        cycle(1, 0, 0, 0, 1, 0, 1);
        expect_eq("t6_addr", {32'b0, imem_addr32}, 64'h100);
        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            cycle(($urandom_range(63) == 0), ($urandom_range(7) == 0),
                  $urandom & 32'hFFFF_FFFC, 16'($urandom),
                  ($urandom_range(4) == 0), ($urandom_range(7) == 0),
                  ($urandom_range(4) != 0));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
